vector_mem_port_sequencer: RTL and testbench

//  Sequences one strided vector load/store into a dual-port, byte-addressed, 32-bit RAM
//  (18-bit byte address, 4 byte enables, 1-cycle synchronous read, offset rotation done in the RAM).

---
 rtl/vector_mem_port_sequencer.sv | 191 +++++++++++++++++++
 tb/tb_vector_mem_port_sequencer.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/vector_mem_port_sequencer.sv
// Strided vector load/store sequencer for a dual-port byte-addressed 32-bit RAM.
// Issues two elements per cycle and returns one assembled response per request.
module vector_mem_port_sequencer #(
  parameter int unsigned LANES = 8
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  logic                       req_store,
  input  logic [1:0]                 req_size,
  input  logic                       req_signed,
  input  logic [17:0]                req_base,
  input  logic [17:0]                req_stride,
  input  logic [$clog2(LANES+1)-1:0] req_count,
  input  logic [LANES*32-1:0]        req_wdata,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [LANES*32-1:0]        resp_rdata,
  output logic [17:0]                address_1,
  output logic [17:0]                address_2,
  output logic [31:0]                data_in_1,
  output logic [31:0]                data_in_2,
  output logic [3:0]                 byte_enablers_1,
  output logic [3:0]                 byte_enablers_2,
  output logic                       write_enable_1,
  output logic                       write_enable_2,
  input  logic [31:0]                data_out_1,
  input  logic [31:0]                data_out_2
);

  localparam int unsigned CW = $clog2(LANES + 1);
  localparam int unsigned IW = CW + 1;
  localparam int unsigned DW = LANES * 32;

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StResp} state_e;

  state_e          r_state;
  state_e          w_state_d;
  logic            r_store;
  logic [1:0]      r_size;
  logic            r_signed;
  logic [17:0]     r_stride;
  logic [CW-1:0]   r_count;
  logic [DW-1:0]   r_wdata;
  logic [17:0]     r_addr1;
  logic [17:0]     r_addr2;
  logic [CW-1:0]   r_pair;
  logic            r_pend1;
  logic            r_pend2;
  logic [CW-1:0]   r_pend_pair;
  logic [DW-1:0]   r_rbuf;
  logic [DW-1:0]   w_rbuf_d;

  logic [CW-1:0]   w_count_in;
  logic [IW-1:0]   w_cnt_ext;
  logic [IW-1:0]   w_idx1;
  logic [IW-1:0]   w_idx2;
  logic [IW-1:0]   w_next_idx;
  logic            w_act2;
  logic            w_last;
  logic            w_collide;
  logic            w_accept;
  logic [3:0]      w_be;

  function automatic logic [31:0] f_extend(input logic [31:0] d, input logic [1:0] sz,
                                           input logic sgn);
    case (sz)
      2'd0:    return {{24{sgn & d[7]}}, d[7:0]};
      2'd1:    return {{16{sgn & d[15]}}, d[15:0]};
      default: return d;
    endcase
  endfunction

  assign w_count_in = (req_count > CW'(LANES)) ? CW'(LANES) : req_count;
  assign w_cnt_ext  = {1'b0, r_count};
  assign w_idx1     = {r_pair, 1'b0};
  assign w_idx2     = {r_pair, 1'b1};
  assign w_next_idx = w_idx1 + IW'(2);
  assign w_act2     = w_idx2 < w_cnt_ext;
  assign w_last     = w_next_idx >= w_cnt_ext;
  // Same-address pair: only the higher-indexed element (port 2) is written.
  assign w_collide  = w_act2 && (r_addr1 == r_addr2);
  assign w_accept   = (r_state == StIdle) && req_valid;
  assign w_be       = (r_size == 2'd0) ? 4'b0001 : (r_size == 2'd1) ? 4'b0011 : 4'b1111;
  assign resp_rdata = r_rbuf;

  always_comb begin
    w_state_d       = r_state;
    req_ready       = 1'b0;
    resp_valid      = 1'b0;
    address_1       = '0;
    address_2       = '0;
    data_in_1       = '0;
    data_in_2       = '0;
    byte_enablers_1 = '0;
    byte_enablers_2 = '0;
    write_enable_1  = 1'b0;
    write_enable_2  = 1'b0;
    unique case (r_state)
      StIdle: begin
        req_ready = 1'b1;
        if (req_valid) begin
          w_state_d = (w_count_in == '0) ? StResp : StIssue;
        end
      end
      StIssue: begin
        address_1       = r_addr1;
        byte_enablers_1 = w_be;
        data_in_1       = r_store ? r_wdata[31:0] : 32'd0;
        // Strobes are gated by reset so an aborted request writes nothing further.
        write_enable_1  = r_store & ~w_collide & ~reset;
        if (w_act2) begin
          address_2       = r_addr2;
          byte_enablers_2 = w_be;
          data_in_2       = r_store ? r_wdata[63:32] : 32'd0;
          write_enable_2  = r_store & ~reset;
        end
        if (w_last) begin
          w_state_d = r_store ? StResp : StDrain;
        end
      end
      StDrain: w_state_d = StResp;
      StResp: begin
        resp_valid = 1'b1;
        if (resp_ready) begin
          w_state_d = StIdle;
        end
      end
      default: w_state_d = StIdle;
    endcase
  end

  always_comb begin
    w_rbuf_d = r_rbuf;
    for (int i = 0; i < LANES; i++) begin
      if (r_pend1 && (IW'(i) == {r_pend_pair, 1'b0})) begin
        w_rbuf_d[32*i +: 32] = f_extend(data_out_1, r_size, r_signed);
      end
      if (r_pend2 && (IW'(i) == {r_pend_pair, 1'b1})) begin
        w_rbuf_d[32*i +: 32] = f_extend(data_out_2, r_size, r_signed);
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state     <= StIdle;
      r_store     <= 1'b0;
      r_size      <= '0;
      r_signed    <= 1'b0;
      r_stride    <= '0;
      r_count     <= '0;
      r_wdata     <= '0;
      r_addr1     <= '0;
      r_addr2     <= '0;
      r_pair      <= '0;
      r_pend1     <= 1'b0;
      r_pend2     <= 1'b0;
      r_pend_pair <= '0;
      r_rbuf      <= '0;
    end else begin
      r_state     <= w_state_d;
      r_pend1     <= (r_state == StIssue) && !r_store;
      r_pend2     <= (r_state == StIssue) && !r_store && w_act2;
      r_pend_pair <= r_pair;
      if (w_accept) begin
        r_store  <= req_store;
        r_size   <= req_size;
        r_signed <= req_signed;
        r_stride <= req_stride;
        r_count  <= w_count_in;
        r_wdata  <= req_wdata;
        r_addr1  <= req_base;
        r_addr2  <= req_base + req_stride;
        r_pair   <= '0;
        r_rbuf   <= '0;
      end else begin
        r_rbuf <= w_rbuf_d;
        if (r_state == StIssue) begin
          // Running accumulators advance both ports by two strides per pair.
          r_pair  <= r_pair + CW'(1);
          r_addr1 <= r_addr1 + {r_stride[16:0], 1'b0};
          r_addr2 <= r_addr2 + {r_stride[16:0], 1'b0};
          r_wdata <= r_wdata >> 64;
        end
      end
    end
  end

endmodule

// File: tb/tb_vector_mem_port_sequencer.sv
// Directed bench for vector_mem_port_sequencer: table of load/store vectors against a
// byte-addressed dual-port RAM model, plus hand sequences for stride-0, stall and reset cases.
module tb_vector_mem_port_sequencer;

  localparam int unsigned LANES = 8;

  logic         clock;
  logic         reset;
  logic         req_valid;
  logic         req_ready;
  logic         req_store;
  logic [1:0]   req_size;
  logic         req_signed;
  logic [17:0]  req_base;
  logic [17:0]  req_stride;
  logic [3:0]   req_count;
  logic [255:0] req_wdata;
  logic         resp_valid;
  logic         resp_ready;
  logic [255:0] resp_rdata;
  logic [17:0]  address_1, address_2;
  logic [31:0]  data_in_1, data_in_2;
  logic [3:0]   byte_enablers_1, byte_enablers_2;
  logic         write_enable_1, write_enable_2;
  logic [31:0]  data_out_1, data_out_2;

  logic [7:0]   mem [0:262143];
  int           total;
  int           bad;
  int           strobes;
  int           collide;
  int           be_bad;
  logic [3:0]   exp_be;

  vector_mem_port_sequencer #(.LANES(LANES)) dut (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_ready(req_ready),
    .req_store(req_store), .req_size(req_size), .req_signed(req_signed),
    .req_base(req_base), .req_stride(req_stride), .req_count(req_count),
    .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_ready(resp_ready),
    .resp_rdata(resp_rdata), .address_1(address_1), .address_2(address_2),
    .data_in_1(data_in_1), .data_in_2(data_in_2), .byte_enablers_1(byte_enablers_1),
    .byte_enablers_2(byte_enablers_2), .write_enable_1(write_enable_1),
    .write_enable_2(write_enable_2), .data_out_1(data_out_1), .data_out_2(data_out_2)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  function automatic logic [31:0] f_rd(input logic [17:0] a);
    return {mem[a + 18'd3], mem[a + 18'd2], mem[a + 18'd1], mem[a]};
  endfunction

  // RAM model: 1-cycle read of the 4 bytes starting at the address, byte-enabled writes,
  // port 2 applied last.
  always @(posedge clock) begin
    data_out_1 <= f_rd(address_1);
    data_out_2 <= f_rd(address_2);
    if (write_enable_1 && write_enable_2 && address_1 == address_2) collide++;
    if (write_enable_1 && byte_enablers_1 != exp_be) be_bad++;
    if (write_enable_2 && byte_enablers_2 != exp_be) be_bad++;
    strobes += int'(write_enable_1) + int'(write_enable_2);
    if (write_enable_1)
      for (int j = 0; j < 4; j++)
        if (byte_enablers_1[j]) mem[address_1 + 18'(j)] = data_in_1[8*j +: 8];
    if (write_enable_2)
      for (int j = 0; j < 4; j++)
        if (byte_enablers_2[j]) mem[address_2 + 18'(j)] = data_in_2[8*j +: 8];
  end

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%h want=%h", nm, act, exp);
    end
  endtask

  task automatic poke32(input logic [17:0] a, input logic [31:0] d);
    for (int j = 0; j < 4; j++) mem[a + 18'(j)] = d[8*j +: 8];
  endtask

  task automatic accept(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [17:0] base, input logic [17:0] stride,
                        input logic [3:0] cnt, input logic [255:0] wd);
    @(negedge clock);
    req_store = st; req_size = sz; req_signed = sg; req_base = base;
    req_stride = stride; req_count = cnt; req_wdata = wd; req_valid = 1'b1;
    chk("ready_before_req", 256'(req_ready), 256'd1);
    @(posedge clock);
    #1 req_valid = 1'b0;
  endtask

  task automatic do_req(input logic st, input logic [1:0] sz, input logic sg,
                        input logic [17:0] base, input logic [17:0] stride,
                        input logic [3:0] cnt, input logic [255:0] wd,
                        output logic [255:0] rdata, output int lat);
    accept(st, sz, sg, base, stride, cnt, wd);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clock);
      if (resp_valid) begin
        lat = c;
        break;
      end
    end
    rdata = resp_rdata;
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
  endtask

  typedef struct {
    string        name;
    logic         store;
    logic [1:0]   size;
    logic         sgn;
    logic [17:0]  base;
    logic [17:0]  stride;
    logic [3:0]   count;
    logic [255:0] wdata;
    logic [255:0] exp_rdata;
    int           exp_lat;
  } vec_t;

  vec_t         vecs [9];
  logic [255:0] rd;
  int           lat;
  int           s0;

  initial begin
    total = 0; bad = 0; strobes = 0; collide = 0; be_bad = 0; exp_be = 4'b1111;
    reset = 1'b1; req_valid = 1'b0; resp_ready = 1'b0; req_store = 1'b0; req_size = '0;
    req_signed = 1'b0; req_base = '0; req_stride = '0; req_count = '0; req_wdata = '0;
    for (int i = 0; i < 262144; i++) mem[i] = 8'h00;
    poke32(18'h100, 32'h11); poke32(18'h104, 32'h22);
    poke32(18'h108, 32'h33); poke32(18'h10C, 32'h44);
    mem[18'h3FFFE] = 8'h01; mem[18'h3FFFF] = 8'h80; mem[18'h00000] = 8'hFF; mem[18'h00001] = 8'h7F;
    mem[18'h400] = 8'h80; mem[18'h401] = 8'h7F; mem[18'h402] = 8'hFF; mem[18'h403] = 8'h01;

    vecs[0] = '{"word_load", 1'b0, 2'd2, 1'b0, 18'h100, 18'd4, 4'd4, 256'd0,
                {128'd0, 32'h44, 32'h33, 32'h22, 32'h11}, 4};
    vecs[1] = '{"half_load_signed_wrap", 1'b0, 2'd1, 1'b1, 18'h3FFFE, 18'd2, 4'd2, 256'd0,
                {192'd0, 32'h00007FFF, 32'hFFFF8001}, 3};
    vecs[2] = '{"half_load_unsigned_wrap", 1'b0, 2'd1, 1'b0, 18'h3FFFE, 18'd2, 4'd2, 256'd0,
                {192'd0, 32'h00007FFF, 32'h00008001}, 3};
    vecs[3] = '{"byte_load_signed_odd", 1'b0, 2'd0, 1'b1, 18'h400, 18'd1, 4'd3, 256'd0,
                {160'd0, 32'hFFFFFFFF, 32'h0000007F, 32'hFFFFFF80}, 4};
    vecs[4] = '{"byte_load_neg_stride", 1'b0, 2'd0, 1'b0, 18'h403, 18'h3FFFF, 4'd4, 256'd0,
                {128'd0, 32'h80, 32'h7F, 32'hFF, 32'h01}, 4};
    vecs[5] = '{"count0_load", 1'b0, 2'd2, 1'b0, 18'h100, 18'd4, 4'd0, 256'd0, 256'd0, 1};
    vecs[6] = '{"count_clamp", 1'b0, 2'd2, 1'b0, 18'h100, 18'd4, 4'd15, 256'd0,
                {128'd0, 32'h44, 32'h33, 32'h22, 32'h11}, 6};
    vecs[7] = '{"reserved_size_word", 1'b0, 2'd3, 1'b0, 18'h104, 18'd8, 4'd2, 256'd0,
                {192'd0, 32'h44, 32'h22}, 3};
    vecs[8] = '{"word_store", 1'b1, 2'd2, 1'b0, 18'h500, 18'd4, 4'd2,
                {192'd0, 32'h12345678, 32'hDEADBEEF}, 256'd0, 2};

    repeat (3) @(posedge clock);
    @(negedge clock);
    chk("reset_req_ready", 256'(req_ready), 256'd1);
    chk("reset_resp_valid", 256'(resp_valid), 256'd0);
    chk("reset_resp_rdata", resp_rdata, 256'd0);
    chk("reset_we", 256'({write_enable_1, write_enable_2}), 256'd0);
    chk("reset_addr", 256'({address_1, address_2}), 256'd0);
    reset = 1'b0;

    for (int v = 0; v < 9; v++) begin
      do_req(vecs[v].store, vecs[v].size, vecs[v].sgn, vecs[v].base, vecs[v].stride,
             vecs[v].count, vecs[v].wdata, rd, lat);
      chk({vecs[v].name, "_rdata"}, rd, vecs[v].exp_rdata);
      chk({vecs[v].name, "_latency"}, 256'(lat), 256'(vecs[v].exp_lat));
    end
    chk("word_store_mem0", 256'(f_rd(18'h500)), 256'h DEADBEEF);
    chk("word_store_mem1", 256'(f_rd(18'h504)), 256'h12345678);

    // Byte store with junk in upper bytes of each element; neighbours must survive.
    mem[18'h202] = 8'h11; mem[18'h206] = 8'h66; exp_be = 4'b0001; be_bad = 0;
    do_req(1'b1, 2'd0, 1'b0, 18'h203, 18'd1, 4'd3,
           {160'd0, 32'h000077CC, 32'h987654BB, 32'h123456AA}, rd, lat);
    chk("byte_store_bytes", 256'({mem[18'h206], mem[18'h205], mem[18'h204], mem[18'h203],
                                   mem[18'h202]}), 256'h66CCBBAA11);
    chk("byte_store_be", 256'(be_bad), 256'd0);
    chk("byte_store_latency", 256'(lat), 256'd3);
    exp_be = 4'b1111;

    // Stride-0 store: port 1 suppressed on the colliding pair, last element wins.
    strobes = 0; collide = 0;
    do_req(1'b1, 2'd2, 1'b0, 18'h600, 18'd0, 4'd3, {160'd0, 32'd3, 32'd2, 32'd1}, rd, lat);
    chk("stride0_mem", 256'(f_rd(18'h600)), 256'd3);
    chk("stride0_collide", 256'(collide), 256'd0);
    chk("stride0_strobes", 256'(strobes), 256'd2);

    // count=0 after a load leaves stale data: response must be zero and held while stalled.
    do_req(1'b0, 2'd2, 1'b0, 18'h100, 18'd4, 4'd4, 256'd0, rd, lat);
    s0 = strobes;
    accept(1'b0, 2'd2, 1'b0, 18'h100, 18'd4, 4'd0, 256'd0);
    for (int c = 1; c <= 6; c++) begin
      @(negedge clock);
      chk($sformatf("stall_valid_c%0d", c), 256'(resp_valid), 256'd1);
      chk($sformatf("stall_rdata_c%0d", c), resp_rdata, 256'd0);
    end
    resp_ready = 1'b1;
    @(posedge clock);
    #1 resp_ready = 1'b0;
    @(negedge clock);
    chk("stall_release_valid", 256'(resp_valid), 256'd0);
    chk("stall_release_ready", 256'(req_ready), 256'd1);
    chk("count0_no_strobe", 256'(strobes - s0), 256'd0);

    // Reset during the second ISSUE cycle of an 8-element store.
    accept(1'b1, 2'd2, 1'b0, 18'h700, 18'd4, 4'd8,
           {32'hA7, 32'hA6, 32'hA5, 32'hA4, 32'hA3, 32'hA2, 32'hA1, 32'hA0});
    @(negedge clock);
    @(negedge clock);
    reset = 1'b1;
    @(posedge clock);
    #1;
    chk("abort_req_ready", 256'(req_ready), 256'd1);
    chk("abort_resp_valid", 256'(resp_valid), 256'd0);
    @(negedge clock);
    reset = 1'b0;
    repeat (3) @(negedge clock);
    chk("abort_mem_e0", 256'(f_rd(18'h700)), 256'hA0);
    chk("abort_mem_e1", 256'(f_rd(18'h704)), 256'hA1);
    chk("abort_mem_e2", 256'(f_rd(18'h708)), 256'd0);
    chk("abort_mem_e3", 256'(f_rd(18'h70C)), 256'd0);
    chk("abort_mem_e7", 256'(f_rd(18'h71C)), 256'd0);
    chk("abort_idle_we", 256'({write_enable_1, write_enable_2}), 256'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
